// File: rtl/timer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_arbiter_if
// Description : Requester-side bus of timer_arbiter: level requests,
//               per-requester durations, grant/expire vectors and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_arbiter_if #(
    parameter int NREQ = 4,
    parameter int CBIT = 6
);
    logic [NREQ-1:0]      req;
    logic [NREQ*CBIT-1:0] dur;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      expire;
    logic                 busy;
    logic [CBIT-1:0]      rema;

    // Arbiter side
    modport slave (
        input  req,
        input  dur,
        output gnt,
        output expire,
        output busy,
        output rema
    );

    // Requester side
    modport master (
        output req,
        output dur,
        input  gnt,
        input  expire,
        input  busy,
        input  rema
    );
endinterface
`default_nettype wire

// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : timer_arbiter
// Description : Round-robin scheduler sharing one nested countdown timer
//               between NREQ requesters. Grants, loads/clears the timer,
//               waits for done, pulses the owner's expire line, releases.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_arbiter #(
    parameter int NREQ = 4,
    parameter int CBIT = 6
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    timer_arbiter_if.slave       bus,
    input  wire logic            pau,
    output logic [CBIT-1:0]      tm_init,
    output logic                 tm_clr,
    output logic                 tm_pau,
    input  wire logic            tm_done,
    input  wire logic [CBIT-1:0] tm_rema
);

    localparam int c_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_EXPIRE = 2'd3
    } state_t;

    state_t             r_state;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_expire;
    logic               r_busy;
    logic               r_tm_clr;
    logic [CBIT-1:0]    r_tm_init;
    logic [c_IDX_W-1:0] r_last;     // last granted requester == current owner

    state_t             w_state_nxt;
    logic [NREQ-1:0]    w_gnt_nxt;
    logic [NREQ-1:0]    w_expire_nxt;
    logic [CBIT-1:0]    w_tm_init_nxt;
    logic [c_IDX_W-1:0] w_last_nxt;
    logic               w_found;
    logic [c_IDX_W-1:0] w_pick;
    logic [CBIT-1:0]    w_pick_dur;

    // Round-robin search starting one past the last owner, with wrap-around
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && bus.req[(int'(r_last) + k) % NREQ]) begin
                w_found = 1'b1;
                w_pick  = c_IDX_W'((int'(r_last) + k) % NREQ);
            end
        end
    end

    assign w_pick_dur = bus.dur[int'(w_pick)*CBIT +: CBIT];

    // Next-state and next-output logic; pause freezes every state but IDLE
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_expire_nxt  = '0;
        w_tm_init_nxt = r_tm_init;
        w_last_nxt    = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt     = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                    w_last_nxt    = w_pick;
                    w_tm_init_nxt = w_pick_dur;
                    // A zero count cannot be timed; go straight to expiry
                    w_state_nxt   = (w_pick_dur == '0) ? S_EXPIRE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (!pau) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!pau) begin
                    // Cancel wins over a simultaneous done
                    if (!bus.req[r_last]) begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = '0;
                    end else if (tm_done) begin
                        w_state_nxt  = S_EXPIRE;
                        w_expire_nxt = r_gnt;
                    end
                end
            end
            S_EXPIRE: begin
                if (pau) begin
                    w_expire_nxt = r_expire;
                end else if (r_expire == '0) begin
                    // Entered from IDLE on a zero duration: pulse one cycle late
                    w_expire_nxt = r_gnt;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_expire  <= '0;
            r_busy    <= 1'b0;
            r_tm_clr  <= 1'b0;
            r_tm_init <= '0;
            r_last    <= c_IDX_W'(NREQ - 1);
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_expire  <= w_expire_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_tm_clr  <= (w_state_nxt == S_LOAD);
            r_tm_init <= w_tm_init_nxt;
            r_last    <= w_last_nxt;
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.expire = r_expire;
    assign bus.busy   = r_busy;
    assign bus.rema   = (r_state == S_RUN) ? tm_rema : '0;
    assign tm_init    = r_tm_init;
    assign tm_clr     = r_tm_clr;
    assign tm_pau     = pau;

endmodule
`default_nettype wire

// File: tb/tb_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_arbiter
// Description : Directed self-checking bench for timer_arbiter paired with a
//               behavioural nested countdown timer (inner period 10 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_arbiter;

    localparam int NREQ       = 4;
    localparam int CBIT       = 6;
    localparam int INNER_CMAX = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            pau;
    logic [CBIT-1:0] tm_init;
    logic            tm_clr;
    logic            tm_pau;
    logic            tm_done;
    logic [CBIT-1:0] tm_rema;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    timer_arbiter_if #(.NREQ(NREQ), .CBIT(CBIT)) bus ();

    timer_arbiter #(.NREQ(NREQ), .CBIT(CBIT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .pau     (pau),
        .tm_init (tm_init),
        .tm_clr  (tm_clr),
        .tm_pau  (tm_pau),
        .tm_done (tm_done),
        .tm_rema (tm_rema)
    );

    // Behavioural nested timer: tick every INNER_CMAX cycles, done one cycle
    // after the tick that brings the count to zero, then self-reload.
    logic [3:0]      inner;
    logic [CBIT-1:0] cnt;
    logic            done_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inner  <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else if (!tm_pau) begin
            if (tm_clr) begin
                inner  <= '0;
                cnt    <= tm_init;
                done_r <= 1'b0;
            end else if (done_r) begin
                done_r <= 1'b0;
                cnt    <= tm_init;
                inner  <= '0;
            end else if (int'(inner) == INNER_CMAX - 1) begin
                inner <= '0;
                if (cnt != '0) cnt <= cnt - 1'b1;
                if (cnt == 1)  done_r <= 1'b1;
            end else begin
                inner <= inner + 1'b1;
            end
        end
    end

    assign tm_done = done_r;
    assign tm_rema = cnt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until a grant is visible; n = negedges waited
    task automatic wait_gnt(output int n);
        n = 0;
        while (bus.gnt == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("gnt_arrives", 32'(bus.gnt != '0), 32'd1);
    endtask

    // Serve one grant to completion: check owner, gap and single expire
    task automatic serve(input logic [3:0] exp_g, input int exp_gap, input string tag);
        int n;
        int ex_cnt;
        logic [3:0] ex_or;
        wait_gnt(n);
        if (exp_gap >= 0) check_eq({tag, "_gap"}, n, exp_gap);
        check_eq({tag, "_gnt"}, bus.gnt, exp_g);
        ex_cnt = 0;
        ex_or  = '0;
        n      = 0;
        while (bus.gnt != '0 && n < 200) begin
            if (bus.expire != '0) ex_cnt++;
            ex_or = ex_or | bus.expire;
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_expcnt"}, ex_cnt, 1);
        check_eq({tag, "_expbit"}, ex_or, exp_g);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] ex_or;

        bus.req = '0;
        bus.dur = '0;
        pau     = 1'b0;
        rst_n   = 1'b0;
        cyc(2);
        // Reset state
        check_eq("rst_gnt",    bus.gnt,    0);
        check_eq("rst_expire", bus.expire, 0);
        check_eq("rst_busy",   bus.busy,   0);
        check_eq("rst_clr",    tm_clr,     0);
        check_eq("rst_init",   tm_init,    0);
        check_eq("rst_rema",   bus.rema,   0);
        rst_n = 1'b1;
        cyc(1);

        // Test 1: single request, duration 3
        bus.dur = {6'd0, 6'd0, 6'd0, 6'd3};
        bus.req = 4'b0001;
        wait_gnt(n);
        check_eq("t1_lat",   n, 1);
        check_eq("t1_gnt",   bus.gnt, 4'b0001);
        check_eq("t1_clr",   tm_clr, 1);
        check_eq("t1_init",  tm_init, 3);
        check_eq("t1_busy",  bus.busy, 1);
        cyc(1);
        check_eq("t1_clr_off", tm_clr, 0);
        check_eq("t1_rema3", bus.rema, 3);
        cyc(10);
        check_eq("t1_rema2", bus.rema, 2);
        cyc(10);
        check_eq("t1_rema1", bus.rema, 1);
        cyc(10);
        check_eq("t1_rema0", bus.rema, 0);
        check_eq("t1_noexp", bus.expire, 0);
        cyc(1);
        check_eq("t1_exp",   bus.expire, 4'b0001);
        check_eq("t1_gnt_hold", bus.gnt, 4'b0001);
        bus.req = '0;
        cyc(1);
        check_eq("t1_exp_off", bus.expire, 0);
        check_eq("t1_gnt_off", bus.gnt, 0);
        check_eq("t1_busy_off", bus.busy, 0);
        cyc(2);

        // Test 2: round-robin over 1011 with duration 1
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        bus.dur = {6'd1, 6'd1, 6'd1, 6'd1};
        bus.req = 4'b1011;
        serve(4'b0001, -1, "rr0");
        serve(4'b0010,  1, "rr1");
        serve(4'b1000,  1, "rr2");
        serve(4'b0001,  1, "rr3");
        serve(4'b0010,  1, "rr4");
        serve(4'b1000,  1, "rr5");
        bus.req = '0;
        cyc(3);

        // Test 3: zero duration on requester 2
        bus.dur = {6'd1, 6'd0, 6'd1, 6'd1};
        bus.req = 4'b0100;
        wait_gnt(n);
        check_eq("t3_gnt",    bus.gnt, 4'b0100);
        check_eq("t3_noexp",  bus.expire, 0);
        check_eq("t3_clr_a",  tm_clr, 0);
        cyc(1);
        check_eq("t3_exp",    bus.expire, 4'b0100);
        check_eq("t3_gnt_h",  bus.gnt, 4'b0100);
        check_eq("t3_clr_b",  tm_clr, 0);
        check_eq("t3_rema",   bus.rema, 0);
        bus.req = '0;
        cyc(1);
        check_eq("t3_gnt_off", bus.gnt, 0);
        check_eq("t3_exp_off", bus.expire, 0);
        cyc(2);

        // Test 4a: cancel after two ticks
        bus.dur = {6'd0, 6'd0, 6'd5, 6'd0};
        bus.req = 4'b0010;
        wait_gnt(n);
        check_eq("t4a_gnt", bus.gnt, 4'b0010);
        cyc(25);
        check_eq("t4a_rema", bus.rema, 3);
        bus.req = '0;
        cyc(1);
        check_eq("t4a_gnt_off", bus.gnt, 0);
        check_eq("t4a_busy",    bus.busy, 0);
        ex_or = bus.expire;
        cyc(1);
        ex_or = ex_or | bus.expire;
        cyc(1);
        ex_or = ex_or | bus.expire;
        check_eq("t4a_noexp", ex_or, 0);
        cyc(2);

        // Test 4b: drop request in the same cycle as done
        bus.dur = {6'd0, 6'd0, 6'd1, 6'd0};
        bus.req = 4'b0010;
        wait_gnt(n);
        cyc(11);
        check_eq("t4b_rema0", bus.rema, 0);
        check_eq("t4b_busy",  bus.busy, 1);
        bus.req = '0;
        cyc(1);
        check_eq("t4b_noexp", bus.expire, 0);
        check_eq("t4b_gnt",   bus.gnt, 0);
        check_eq("t4b_idle",  bus.busy, 0);
        cyc(3);

        // Test 5: pause 7 cycles in LOAD and 25 cycles in RUN
        bus.dur = {6'd0, 6'd0, 6'd0, 6'd3};
        bus.req = 4'b0001;
        wait_gnt(n);
        pau = 1'b1;
        cyc(3);
        check_eq("t5_clr_held3", tm_clr, 1);
        check_eq("t5_tm_pau",    tm_pau, 1);
        cyc(4);
        check_eq("t5_clr_held7", tm_clr, 1);
        pau = 1'b0;
        cyc(1);
        check_eq("t5_clr_off", tm_clr, 0);
        cyc(4);
        check_eq("t5_rema_pre", bus.rema, 3);
        pau = 1'b1;
        cyc(8);
        check_eq("t5_rema_frz", bus.rema, 3);
        cyc(17);
        check_eq("t5_rema_rel", bus.rema, 3);
        pau = 1'b0;
        cyc(26);
        check_eq("t5_noexp63", bus.expire, 0);
        cyc(1);
        check_eq("t5_exp64",   bus.expire, 4'b0001);
        bus.req = '0;
        cyc(1);
        check_eq("t5_gnt_off", bus.gnt, 0);
        cyc(2);

        // Test 6: asynchronous reset mid-RUN
        bus.req = 4'b0001;
        wait_gnt(n);
        cyc(5);
        check_eq("t6_gnt_run", bus.gnt, 4'b0001);
        rst_n = 1'b0;
        #1;
        check_eq("t6_gnt_rst",  bus.gnt, 0);
        check_eq("t6_busy_rst", bus.busy, 0);
        check_eq("t6_clr_rst",  tm_clr, 0);
        check_eq("t6_exp_rst",  bus.expire, 0);
        bus.req = 4'b0011;
        cyc(2);
        rst_n = 1'b1;
        wait_gnt(n);
        check_eq("t6_first", bus.gnt, 4'b0001);
        bus.req = '0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
